// File: rtl/ttt_board.sv
// N x N tic-tac-toe board with move arbitration, turn tracking
// and sequential line-by-line win/draw detection.
module ttt_board #(
  parameter int N = 3,
  localparam int RW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            move_valid,
  output logic            move_ready,
  input  logic [RW-1:0]   move_row,
  input  logic [RW-1:0]   move_col,
  output logic            move_accept,
  output logic            move_reject,
  output logic            turn,
  output logic [N*N-1:0]  board_valid,
  output logic [N*N-1:0]  board_symbol,
  output logic [6:0]      move_count,
  output logic            game_over,
  output logic            winner_valid,
  output logic            winner,
  output logic            draw
);

  localparam int NN = N * N;
  localparam int LN = 2 * N + 2;
  localparam int LW = $clog2(LN);
  localparam int IW = $clog2(NN);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("ttt_board: N must be in 2..8");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [NN-1:0]   r_valid;
  logic [NN-1:0]   r_sym;
  logic            r_turn;
  logic [6:0]      r_count;
  logic            r_accept;
  logic            r_reject;
  logic            r_over;
  logic            r_winv;
  logic            r_winner;
  logic            r_draw;
  logic [LW-1:0]   r_line;
  logic            r_match;
  logic            r_player;

  logic [NN-1:0]   w_sel;
  logic            w_xfer;
  logic            w_legal;
  logic            w_hit;
  logic            w_last;
  logic            w_win;
  logic            w_full;
  int              w_lnum;
  logic [IW-1:0]   w_cell;

  // Ready is masked by reset so every output reads 0 while held in reset
  assign move_ready = (r_state == S_IDLE) & reset;
  assign w_xfer     = move_valid & move_ready;
  assign w_lnum     = int'(r_line);
  assign w_last     = (r_line == LW'(LN - 1));
  assign w_win      = r_match | w_hit;
  assign w_full     = (r_count == 7'(NN));

  // Out-of-range coordinates select no cell, so they read as illegal
  always_comb begin
    w_sel = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        w_sel[r*N+c] = (int'(move_row) == r) &&
                       (int'(move_col) == c);
      end
    end
  end

  assign w_legal = |(w_sel & ~r_valid);

  always_comb begin
    w_hit  = 1'b1;
    w_cell = '0;
    for (int i = 0; i < N; i++) begin
      if (w_lnum < N)
        w_cell = IW'(w_lnum * N + i);
      else if (w_lnum < 2 * N)
        w_cell = IW'(i * N + (w_lnum - N));
      else if (w_lnum == 2 * N)
        w_cell = IW'(i * N + i);
      else
        w_cell = IW'(i * N + (N - 1 - i));
      w_hit = w_hit & r_valid[w_cell] &
              (r_sym[w_cell] == r_player);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (w_xfer && w_legal) w_next = S_CHECK;
        S_CHECK:
          if (w_last) begin
            if (w_win || w_full) w_next = S_DONE;
            else                 w_next = S_IDLE;
          end
        S_DONE:
          w_next = S_DONE;
        default:
          w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid  <= '0;
      r_sym    <= '0;
      r_turn   <= 1'b0;
      r_count  <= '0;
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      r_over   <= 1'b0;
      r_winv   <= 1'b0;
      r_winner <= 1'b0;
      r_draw   <= 1'b0;
      r_line   <= '0;
      r_match  <= 1'b0;
      r_player <= 1'b0;
    end else begin
      r_accept <= 1'b0;
      r_reject <= 1'b0;
      if (clear) begin
        r_valid  <= '0;
        r_sym    <= '0;
        r_turn   <= 1'b0;
        r_count  <= '0;
        r_over   <= 1'b0;
        r_winv   <= 1'b0;
        r_winner <= 1'b0;
        r_draw   <= 1'b0;
        r_line   <= '0;
        r_match  <= 1'b0;
        r_player <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_xfer) begin
              if (w_legal) begin
                r_valid  <= r_valid | w_sel;
                r_sym    <= (r_sym & ~w_sel) |
                            (w_sel & {NN{r_turn}});
                r_count  <= r_count + 7'd1;
                r_accept <= 1'b1;
                r_line   <= '0;
                r_match  <= 1'b0;
                r_player <= r_turn;
              end else begin
                r_reject <= 1'b1;
              end
            end
          end
          S_CHECK: begin
            r_line  <= r_line + LW'(1);
            r_match <= w_win;
            if (w_last) begin
              if (w_win) begin
                r_winv   <= 1'b1;
                r_winner <= r_player;
                r_over   <= 1'b1;
              end else if (w_full) begin
                r_draw <= 1'b1;
                r_over <= 1'b1;
              end else begin
                r_turn <= ~r_turn;
              end
            end
          end
          S_DONE: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign move_accept  = r_accept;
  assign move_reject  = r_reject;
  assign turn         = r_turn;
  assign board_valid  = r_valid;
  assign board_symbol = r_sym;
  assign move_count   = r_count;
  assign game_over    = r_over;
  assign winner_valid = r_winv;
  assign winner       = r_winner;
  assign draw         = r_draw;

endmodule
